// File: rtl/magnitude_shift_add_mult.sv
// magnitude_shift_add_mult: sequential signed-magnitude shift-add multiplier, one multiplier bit per clock.
// Optional MAG_MULT_ZERO_SKIP_EN: zero operands bypass iteration and go straight to sign correction.
module magnitude_shift_add_mult #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   first_mag,
  input  logic [WIDTH-1:0]   second_mag,
  input  logic               first_sign,
  input  logic               second_sign,
  input  logic               mag_valid,
  output logic               busy,
  output logic [2*WIDTH-1:0] product,
  output logic               product_valid
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, ITER, SIGN} state_t;
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d, mplier_q, mplier_d;
  logic [WIDTH:0]     acc_q, acc_d, sum;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d, pv_q, pv_d;
  logic [2*WIDTH-1:0] product_q, product_d, result;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      pv_q      <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      pv_q      <= pv_d;
      product_q <= product_d;
    end
  // acc carries one extra bit so the add never loses the carry before the shift
  assign sum    = acc_q + {1'b0, mplier_q[0] ? mcand_q : '0};
  assign result = {acc_q[WIDTH-1:0], mplier_q};
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    pv_d      = 1'b0;
    product_d = product_q;
    case (state_q)
      IDLE: if (mag_valid) begin
        mcand_d  = first_mag;
        mplier_d = second_mag;
        neg_d    = first_sign ^ second_sign;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = ITER;
`ifdef MAG_MULT_ZERO_SKIP_EN
        if (first_mag == '0 || second_mag == '0) begin
          mplier_d = '0;
          state_d  = SIGN;
        end
`else
`endif
      end
      ITER: begin
        acc_d    = {1'b0, sum[WIDTH:1]};
        mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        state_d  = (cnt_q == CW'(WIDTH-1)) ? SIGN : ITER;
      end
      SIGN: begin
        product_d = neg_q ? (~result + 1'b1) : result;
        pv_d      = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy          = (state_q != IDLE);
  assign product       = product_q;
  assign product_valid = pv_q;
endmodule

// File: tb/tb_magnitude_shift_add_mult.sv
// tb_magnitude_shift_add_mult: directed self-checking bench for the WIDTH=4 signed-magnitude multiplier.
module tb_magnitude_shift_add_mult;
  logic       clk = 1'b0, rst = 1'b1;
  logic [3:0] first_mag = '0, second_mag = '0;
  logic       first_sign = 1'b0, second_sign = 1'b0, mag_valid = 1'b0;
  logic       busy, product_valid;
  logic [7:0] product;
  int tests = 0, fails = 0;
`ifdef MAG_MULT_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 5;
`endif
  magnitude_shift_add_mult #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .first_mag(first_mag), .second_mag(second_mag),
    .first_sign(first_sign), .second_sign(second_sign), .mag_valid(mag_valid),
    .busy(busy), .product(product), .product_valid(product_valid)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [3:0] a, input logic as, input logic [3:0] b, input logic bs);
    first_mag = a; first_sign = as; second_mag = b; second_sign = bs; mag_valid = 1'b1;
    step();
    mag_valid = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if (product !== 8'h00 || product_valid !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_idle cyc%0d: product=%h pv=%b busy=%b, want 00 0 0", i, product, product_valid, busy);
      end
    end
  endtask
  task automatic test_basic();
    start(4'd3, 1'b0, 4'd2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (busy !== 1'b1 || product_valid !== 1'b0) begin
        fails++;
        $display("FAIL basic_busy cyc%0d: busy=%b pv=%b, want 1 0", i, busy, product_valid);
      end
      step();
    end
    tests++;
    if (product_valid !== 1'b1 || product !== 8'hFA || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_result: pv=%b product=%h busy=%b, want 1 FA 0", product_valid, product, busy);
    end
    step();
    tests++;
    if (product_valid !== 1'b0 || product !== 8'hFA) begin
      fails++;
      $display("FAIL basic_hold: pv=%b product=%h, want 0 FA", product_valid, product);
    end
  endtask
  task automatic test_back_to_back();
    start(4'd8, 1'b1, 4'd8, 1'b1);
    repeat (5) step();
    tests++;
    if (product_valid !== 1'b1 || product !== 8'h40) begin
      fails++;
      $display("FAIL b2b_first: pv=%b product=%h, want 1 40", product_valid, product);
    end
    start(4'd7, 1'b0, 4'd7, 1'b0);
    tests++;
    if (busy !== 1'b1 || product_valid !== 1'b0 || product !== 8'h40) begin
      fails++;
      $display("FAIL b2b_accept: busy=%b pv=%b product=%h, want 1 0 40", busy, product_valid, product);
    end
    repeat (5) step();
    tests++;
    if (product_valid !== 1'b1 || product !== 8'h31) begin
      fails++;
      $display("FAIL b2b_second: pv=%b product=%h, want 1 31", product_valid, product);
    end
  endtask
  task automatic test_ignore_busy();
    start(4'd4, 1'b1, 4'd3, 1'b0);
    first_mag = 4'd5; second_mag = 4'd5; first_sign = 1'b0; second_sign = 1'b0;
    mag_valid = 1'b1; step(); mag_valid = 1'b0;
    step();
    mag_valid = 1'b1; step(); mag_valid = 1'b0;
    step(); step();
    tests++;
    if (product_valid !== 1'b1 || product !== 8'hF4) begin
      fails++;
      $display("FAIL ignore_result: pv=%b product=%h, want 1 F4", product_valid, product);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      tests++;
      if (product_valid !== 1'b0 || busy !== 1'b0 || product !== 8'hF4) begin
        fails++;
        $display("FAIL ignore_quiet cyc%0d: pv=%b busy=%b product=%h, want 0 0 F4", i, product_valid, busy, product);
      end
    end
  endtask
  task automatic test_zero();
    int n;
    start(4'd0, 1'b1, 4'd6, 1'b0);
    n = 0;
    while (product_valid !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    tests++;
    if (n != ZLAT || product !== 8'h00) begin
      fails++;
      $display("FAIL zero: edges=%0d product=%h, want %0d 00", n, product, ZLAT);
    end
  endtask
  task automatic test_reset_mid();
    int n;
    start(4'd7, 1'b0, 4'd3, 1'b0);
    step();
    rst = 1'b1;
    step();
    tests++;
    if (product !== 8'h00 || busy !== 1'b0 || product_valid !== 1'b0) begin
      fails++;
      $display("FAIL midrst: product=%h busy=%b pv=%b, want 00 0 0", product, busy, product_valid);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      tests++;
      if (product_valid !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL midrst_quiet cyc%0d: pv=%b busy=%b, want 0 0", i, product_valid, busy);
      end
    end
    start(4'd2, 1'b0, 4'd2, 1'b0);
    n = 0;
    while (product_valid !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    tests++;
    if (n != 5 || product !== 8'h04) begin
      fails++;
      $display("FAIL midrst_new: edges=%0d product=%h, want 5 04", n, product);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_busy();
    test_zero();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
